ebpf_shift_unit: RTL and testbench

- Parametrised, pipelined shift unit for the eBPF core ALU, covering the BPF_LSH, BPF_RSH and BPF_ARSH opcodes in both ALU64 and ALU32 forms.
- Replaces the combinational 32-bit arithmetic-right-shift primitive with one block that handles all three shift kinds.
- Width and pipeline depth are configurable.
- Uses a valid/ready handshake toward the execute stage, and passes a destination-register tag through to writeback.

---
 rtl/ebpf_shift_unit.sv | 126 ++++++++++++
 tb/tb_ebpf_shift_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebpf_shift_unit.sv
// Pipelined LSH/RSH/ARSH unit for the eBPF ALU (ALU64 and ALU32 forms).
// The shift is split into log2(DATA_W) power-of-two steps spread over STAGES register slices.
module ebpf_shift_unit #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic              in_alu32,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam int unsigned SHAMT_W         = $clog2(DATA_W);
    localparam int unsigned HALF_W          = DATA_W / 2;
    localparam int unsigned STEPS_PER_SLICE = (SHAMT_W + STAGES - 1) / STAGES;

    localparam logic [1:0] OP_LSH  = 2'b00;
    localparam logic [1:0] OP_ARSH = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef struct packed {
        logic               vld;
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] amt;
        logic               left;
        logic               fill;
        logic               alu32;
        logic               err;
        logic [TAG_W-1:0]   tag;
    } slice_t;

    slice_t slc_q [STAGES];
    slice_t slc_d [STAGES];
    slice_t src   [STAGES];
    logic   advance;
    logic   sign_ext;
    logic   unused_b;

    // Applies the power-of-two steps owned by one slice; earlier slices own the extra steps.
    function automatic logic [DATA_W-1:0] shift_slice(
        input logic [DATA_W-1:0]  d,
        input logic [SHAMT_W-1:0] amt,
        input logic               left,
        input logic               fill,
        input int unsigned        slice
    );
        logic [DATA_W-1:0] r;
        r = d;
        for (int unsigned k = 0; k < SHAMT_W; k++) begin
            if (((k / STEPS_PER_SLICE) == slice) && amt[k]) begin
                if (left) begin
                    r = r << (1 << k);
                end else if (fill) begin
                    r = ~((~r) >> (1 << k));
                end else begin
                    r = r >> (1 << k);
                end
            end
        end
        return r;
    endfunction

    assign advance  = !slc_q[STAGES-1].vld || out_ready;
    assign in_ready = advance;
    assign unused_b = ^in_b[DATA_W-1:SHAMT_W];

    // Half-width operands are sign-extended for ARSH so one full-width shifter serves both modes.
    always_comb begin
        sign_ext      = (in_op == OP_ARSH) && in_a[HALF_W-1];
        src[0].vld    = in_valid;
        src[0].data   = in_alu32 ? {{HALF_W{sign_ext}}, in_a[HALF_W-1:0]} : in_a;
        src[0].amt    = in_alu32 ? {1'b0, in_b[SHAMT_W-2:0]} : in_b[SHAMT_W-1:0];
        src[0].left   = (in_op == OP_LSH);
        src[0].fill   = (in_op == OP_ARSH) && (in_alu32 ? in_a[HALF_W-1] : in_a[DATA_W-1]);
        src[0].alu32  = in_alu32;
        src[0].err    = (in_op == OP_RSVD);
        src[0].tag    = in_tag;
        for (int unsigned s = 1; s < STAGES; s++) begin
            src[s] = slc_q[s-1];
        end
    end

    // Per-slice shift; the last slice also applies zero-extension and the reserved-op result.
    always_comb begin
        for (int unsigned s = 0; s < STAGES; s++) begin
            slc_d[s]      = src[s];
            slc_d[s].data = shift_slice(src[s].data, src[s].amt, src[s].left, src[s].fill, s);
            if (s == STAGES - 1) begin
                if (src[s].err) begin
                    slc_d[s].data = '0;
                end else if (src[s].alu32) begin
                    slc_d[s].data[DATA_W-1:HALF_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                slc_q[s] <= '0;
            end
        end else if (advance) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                slc_q[s] <= slc_d[s];
            end
        end
    end

    assign out_valid  = slc_q[STAGES-1].vld;
    assign out_result = slc_q[STAGES-1].data;
    assign out_tag    = slc_q[STAGES-1].tag;
    assign out_err    = slc_q[STAGES-1].err;

endmodule

// File: tb/tb_ebpf_shift_unit.sv
// Bench for ebpf_shift_unit: three instances (STAGES 2, 1, 6) share the input stream,
// each with its own result scoreboard fed from an arithmetic reference model.
module tb_ebpf_shift_unit;

    localparam int unsigned N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_op;
    logic        in_alu32;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [3:0]  in_tag;
    logic        i_rdy [N];
    logic        o_vld [N];
    logic        o_rdy [N];
    logic [63:0] o_res [N];
    logic [3:0]  o_tag [N];
    logic        o_err [N];

    always #5 clk = ~clk;

    ebpf_shift_unit #(.DATA_W(64), .STAGES(2), .TAG_W(4)) dut_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_rdy[0]),
        .in_op(in_op), .in_alu32(in_alu32), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(o_vld[0]), .out_ready(o_rdy[0]), .out_result(o_res[0]),
        .out_tag(o_tag[0]), .out_err(o_err[0])
    );
    ebpf_shift_unit #(.DATA_W(64), .STAGES(1), .TAG_W(4)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_rdy[1]),
        .in_op(in_op), .in_alu32(in_alu32), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(o_vld[1]), .out_ready(o_rdy[1]), .out_result(o_res[1]),
        .out_tag(o_tag[1]), .out_err(o_err[1])
    );
    ebpf_shift_unit #(.DATA_W(64), .STAGES(6), .TAG_W(4)) dut_s6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(i_rdy[2]),
        .in_op(in_op), .in_alu32(in_alu32), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(o_vld[2]), .out_ready(o_rdy[2]), .out_result(o_res[2]),
        .out_tag(o_tag[2]), .out_err(o_err[2])
    );

    typedef struct {
        logic [63:0] res;
        logic [3:0]  tag;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        expq [N][$];
    exp_t        cur;
    int          stg [N] = '{2, 1, 6};
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          strict;
    bit          rand_rdy;
    int          stall_left = 0;
    bit          acc0;
    bit          hold_v [N];
    logic [63:0] hold_res [N];
    logic [3:0]  hold_tag [N];
    logic        hold_err [N];

    task automatic check(input int idx, input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[dut%0d] observed=0x%0h expected=0x%0h", name, idx, obs, exp);
        end
    endtask

    // Reference: plain eBPF shift semantics using language operators.
    function automatic logic [63:0] model(input logic [1:0] op, input logic alu32,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [31:0]  x;
        logic [63:0]  y;
        int unsigned  sh;
        if (op == 2'b11) return 64'd0;
        if (alu32) begin
            sh = 32'(b[4:0]);
            x  = a[31:0];
            case (op)
                2'b00:   x = x << sh;
                2'b01:   x = x >> sh;
                default: x = $signed(x) >>> sh;
            endcase
            return {32'd0, x};
        end
        sh = 32'(b[5:0]);
        y  = a;
        case (op)
            2'b00:   y = y << sh;
            2'b01:   y = y >> sh;
            default: y = $signed(y) >>> sh;
        endcase
        return y;
    endfunction

    // One clock: apply ready policy, sample just after the falling edge, score handshakes.
    task automatic step();
        exp_t e;
        int   lat;
        for (int i = 0; i < N; i++) o_rdy[i] = rand_rdy ? ($urandom_range(0, 99) < 70) : 1'b1;
        if (stall_left > 0) begin
            o_rdy[0] = 1'b0;
            stall_left--;
        end
        #1;
        acc0 = 1'b0;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (hold_v[i]) begin
                    check(i, "hold_valid", 64'(o_vld[i]), 64'd1);
                    check(i, "hold_result", o_res[i], hold_res[i]);
                    check(i, "hold_tag", 64'(o_tag[i]), 64'(hold_tag[i]));
                    check(i, "hold_err", 64'(o_err[i]), 64'(hold_err[i]));
                end
                check(i, "in_ready_rule", 64'(i_rdy[i]), 64'(!o_vld[i] || o_rdy[i]));
                if (o_vld[i] && o_rdy[i]) begin
                    if (expq[i].size() == 0) begin
                        check(i, "spurious_out", 64'(o_vld[i]), 64'd0);
                    end else begin
                        e   = expq[i].pop_front();
                        lat = cyc - e.acc;
                        check(i, "result", o_res[i], e.res);
                        check(i, "tag", 64'(o_tag[i]), 64'(e.tag));
                        check(i, "err", 64'(o_err[i]), 64'(e.err));
                        if (strict) check(i, "latency", 64'(lat), 64'(stg[i]));
                        else        check(i, "latency_min", 64'(lat >= stg[i]), 64'd1);
                    end
                end
                hold_v[i]   = o_vld[i] && !o_rdy[i];
                hold_res[i] = o_res[i];
                hold_tag[i] = o_tag[i];
                hold_err[i] = o_err[i];
                if (in_valid && i_rdy[i]) begin
                    e     = cur;
                    e.acc = cyc;
                    expq[i].push_back(e);
                end
            end
            acc0 = in_valid && i_rdy[0];
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [1:0] op, input logic alu32, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] tag,
                        input bit use_exp, input logic [63:0] exp_res);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_alu32 = alu32;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        cur.res  = use_exp ? exp_res : model(op, alu32, a, b);
        cur.tag  = tag;
        cur.err  = (op == 2'b11);
        cur.acc  = 0;
        do begin
            step();
            n++;
        end while (!acc0 && n < 100);
        if (!acc0) check(0, "accept_timeout", 64'(acc0), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 1'b0;
        while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 400) begin
            step();
            n++;
        end
        check(0, "drain_left", 64'(expq[0].size() + expq[1].size() + expq[2].size()), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_alu32 = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_tag   = '0;
        strict   = 1'b1;
        rand_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            o_rdy[i]  = 1'b1;
            hold_v[i] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            check(i, "rst_valid", 64'(o_vld[i]), 64'd0);
            check(i, "rst_result", o_res[i], 64'd0);
            check(i, "rst_tag", 64'(o_tag[i]), 64'd0);
            check(i, "rst_err", 64'(o_err[i]), 64'd0);
            check(i, "rst_in_ready", 64'(i_rdy[i]), 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed cases with hand-derived results, single ops at full readiness.
        send(2'b10, 1'b0, 64'h8000_0000_0000_0010, 64'd4, 4'h5, 1'b1, 64'hF800_0000_0000_0001);
        drain();
        send(2'b10, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 4'h1, 1'b1, 64'h0000_0000_F800_0000);
        drain();
        send(2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 4'h2, 1'b1, 64'h0000_0000_0800_0000);
        drain();
        send(2'b00, 1'b0, 64'd1, 64'h43, 4'h3, 1'b1, 64'd8);
        drain();
        send(2'b00, 1'b0, 64'd1, 64'd63, 4'h4, 1'b1, 64'h8000_0000_0000_0000);
        drain();
        send(2'b11, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 4'h6, 1'b1, 64'd0);
        drain();
        send(2'b00, 1'b0, 64'd5, 64'd0, 4'h7, 1'b1, 64'd5);
        drain();
        send(2'b10, 1'b1, 64'hDEAD_BEEF_9234_5678, 64'h40, 4'h8, 1'b1, 64'h0000_0000_9234_5678);
        drain();

        // Back-to-back stream with a five-cycle output stall on the STAGES=2 instance.
        strict = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) stall_left = 5;
            send(2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 64'($urandom_range(0, 127)), 4'(k), 1'b0, 64'd0);
        end
        drain();

        // Randomised traffic with random back-pressure on all instances.
        rand_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                step();
            end else begin
                send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                     ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70)),
                     4'($urandom), 1'b0, 64'd0);
            end
        end
        drain();

        // Reset with operations in flight, then a clean op afterwards.
        rand_rdy = 1'b0;
        strict   = 1'b1;
        for (int r = 0; r < 2; r++) begin
            step();
            send(2'b00, 1'b0, {$urandom, $urandom}, 64'($urandom_range(0, 63)), 4'hA, 1'b0, 64'd0);
            send(2'b10, 1'b0, {$urandom, $urandom}, 64'($urandom_range(0, 63)), 4'hB, 1'b0, 64'd0);
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            for (int i = 0; i < N; i++) begin
                check(i, "reset_drops_valid", 64'(o_vld[i]), 64'd0);
                expq[i].delete();
                hold_v[i] = 1'b0;
            end
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 8; c++) begin
                step();
                for (int i = 0; i < N; i++) check(i, "post_reset_idle", 64'(o_vld[i]), 64'd0);
            end
            send(2'b01, 1'b1, {$urandom, $urandom}, 64'($urandom_range(0, 63)), 4'hC, 1'b0, 64'd0);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
